call_ret_ctrl: RTL and testbench
================================

CALL_RET_CTRL -- requirements
Module: call_ret_ctrl

Interface
REQ-001 Parameter STACK_DEPTH, default 16, SHALL set the maximum number of outstanding return addresses.
REQ-002 Parameter PC_W, default 12, SHALL set the program-counter width.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1, SHALL be the asynchronous, active-low reset.
REQ-005 Port req_valid, input, 1, SHALL indicate that opcode and pc_in are valid.
REQ-006 Port req_ready, output, 1, SHALL indicate the block can accept a request.
REQ-007 Port opcode, input, 16, SHALL carry the instruction word (2NNN = CALL, 00EE = RET).
REQ-008 Port pc_in, input, PC_W, SHALL carry the address of the current instruction.
REQ-009 Port pc_out, output, PC_W, SHALL carry the new program counter.
REQ-010 Port pc_load, output, 1, SHALL be a one-cycle strobe qualifying pc_out.
REQ-011 Port done, output, 1, SHALL be a one-cycle completion strobe for every accepted request.
REQ-012 Port fault, output, 1, SHALL qualify done as an error completion.
REQ-013 Port fault_code, output, 2, SHALL encode the error: 0 none, 1 overflow, 2 underflow, 3 illegal.
REQ-014 Port stk_push, output, 1, SHALL drive the return-address stack push.
REQ-015 Port stk_pop, output, 1, SHALL drive the return-address stack pop.
REQ-016 Port stk_wdata, output, 16, SHALL carry the push data.
REQ-017 Port stk_rdata, input, 16, SHALL receive stack read data, registered, valid one cycle after a pop.
REQ-018 Port depth, output, $clog2(STACK_DEPTH)+1, SHALL report the current number of stored entries.

Function
REQ-019 FSM states SHALL be IDLE, PUSH, POP, WAIT, DONE, FAULT.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready.
REQ-021 On acceptance, opcode[15:12]==2 with depth<STACK_DEPTH SHALL go to PUSH; with depth==STACK_DEPTH, to FAULT with code 1.
REQ-022 On acceptance, opcode==16'h00EE with depth>0 SHALL go to POP; with depth==0, to FAULT with code 2.
REQ-023 Any other accepted opcode SHALL go to FAULT with code 3.
REQ-024 PUSH SHALL assert stk_push for exactly one cycle with stk_wdata = {zero-extend, pc_in+2 mod 2^PC_W}; it SHALL increment depth, register pc_out = opcode[11:0], and go to DONE.
REQ-025 POP SHALL assert stk_pop for exactly one cycle, decrement depth, and go to WAIT.
REQ-026 WAIT SHALL register pc_out = stk_rdata[PC_W-1:0] and go to DONE.
REQ-027 DONE SHALL assert done=1, pc_load=1, fault=0 for one cycle, then go to IDLE.
REQ-028 FAULT SHALL assert done=1, fault=1, pc_load=0 for one cycle; it SHALL leave depth and the stack unchanged, then go to IDLE.
REQ-029 Latency from acceptance edge to done SHALL be 2 cycles for CALL, 3 cycles for RET, and 1 cycle for FAULT.
REQ-030 stk_push and stk_pop SHALL never be asserted in the same cycle.
REQ-031 Outside PUSH and POP, stk_push and stk_pop SHALL be 0.
REQ-032 pc_in+2 SHALL wrap within PC_W bits (0xFFE -> 0x000).
REQ-033 fault_code SHALL hold its value until the next acceptance and SHALL be 0 after any successful completion.
REQ-034 opcode and pc_in SHALL be sampled only at acceptance; later changes SHALL have no effect.

Reset
REQ-035 Asserting rst_n low at any time, including mid-operation, SHALL immediately force: state IDLE, depth 0, pc_out 0, fault_code 0, and all strobes 0.
REQ-036 The block SHALL treat depth as the architectural stack pointer; the integrating level SHALL discard stack contents whenever this block is reset.

Structure
REQ-037 Shared package chip8_pkg SHALL hold the CALL and RET opcode constants, the fault_code encodings, and the FSM state enum.
REQ-038 The block SHALL NOT instantiate the stack; the CPU top SHALL connect it. No sub-module is required.

Verification
REQ-039 Reset, then CALL 0x2345 with pc_in=0x200 -> stk_push with wdata 0x0202, pc_out=0x345 and pc_load 2 cycles after acceptance, depth=1.
REQ-040 After REQ-039, RET 0x00EE with stk_rdata=0x0202 -> stk_pop, then pc_out=0x202 and done 3 cycles after acceptance, depth=0.
REQ-041 RET with depth=0 -> done and fault with code 2 one cycle after acceptance; no stk_pop; depth stays 0.
REQ-042 Sixteen CALLs, then a 17th CALL -> fault code 1; no stk_push on the 17th; depth stays 16.
REQ-043 Opcode 0x1234 -> fault code 3; pc_load=0. CALL with pc_in=0xFFE -> stk_wdata=0x0000.
REQ-044 rst_n pulsed low during WAIT -> IDLE with req_ready=1, depth=0, no done, no pc_load.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared CHIP-8 control constants: CALL/RET opcodes, fault encodings
// and the call/return sequencer state type.
package chip8_pkg;

    localparam logic [3:0]  OP_CALL_NIB = 4'h2;
    localparam logic [15:0] OP_RET      = 16'h00EE;

    localparam logic [1:0] FC_NONE = 2'd0;
    localparam logic [1:0] FC_OVF  = 2'd1;
    localparam logic [1:0] FC_UNF  = 2'd2;
    localparam logic [1:0] FC_ILL  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH,
        ST_POP,
        ST_WAIT,
        ST_DONE,
        ST_FAULT
    } state_e;

endpackage

// File: rtl/call_ret_ctrl_if.sv
// Request handshake into the call/return sequencer.
// master = instruction issuer, slave = call_ret_ctrl.
interface call_ret_ctrl_if #(
    parameter int PC_W = 12
);
    logic            req_valid;
    logic            req_ready;
    logic [15:0]     opcode;
    logic [PC_W-1:0] pc_in;

    modport master (
        output req_valid, opcode, pc_in,
        input  req_ready
    );

    modport slave (
        input  req_valid, opcode, pc_in,
        output req_ready
    );
endinterface

// File: rtl/call_ret_ctrl.sv
// CALL/RET sequencer: drives an external return-address stack and
// produces the new PC, with overflow/underflow/illegal fault reporting.
module call_ret_ctrl
    import chip8_pkg::*;
#(
    parameter int STACK_DEPTH = 16,
    parameter int PC_W        = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    call_ret_ctrl_if.slave               req,
    output logic [PC_W-1:0]              pc_out,
    output logic                         pc_load,
    output logic                         done,
    output logic                         fault,
    output logic [1:0]                   fault_code,
    output logic                         stk_push,
    output logic                         stk_pop,
    output logic [15:0]                  stk_wdata,
    input  logic [15:0]                  stk_rdata,
    output logic [$clog2(STACK_DEPTH):0] depth
);

    localparam int DW = $clog2(STACK_DEPTH) + 1;

    state_e          state;
    logic [11:0]     tgt_q;
    logic            accept;
    logic            is_call;
    logic            is_ret;
    logic            full;
    logic            empty;
    logic [PC_W-1:0] ret_pc;

    assign req.req_ready = (state == ST_IDLE);
    assign accept  = req.req_valid && req.req_ready;
    assign is_call = (req.opcode[15:12] == OP_CALL_NIB);
    assign is_ret  = (req.opcode == OP_RET);
    assign full    = (depth == DW'(STACK_DEPTH));
    assign empty   = (depth == '0);
    assign ret_pc  = req.pc_in + PC_W'(2);

    // Outputs are registered on the edge entering the state that owns them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            tgt_q      <= '0;
            pc_out     <= '0;
            pc_load    <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            stk_push   <= 1'b0;
            stk_pop    <= 1'b0;
            stk_wdata  <= '0;
            depth      <= '0;
        end else begin
            pc_load  <= 1'b0;
            done     <= 1'b0;
            fault    <= 1'b0;
            stk_push <= 1'b0;
            stk_pop  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        tgt_q      <= req.opcode[11:0];
                        fault_code <= FC_NONE;
                        unique case (1'b1)
                            is_call && !full: begin
                                state     <= ST_PUSH;
                                stk_push  <= 1'b1;
                                stk_wdata <= 16'(ret_pc);
                            end
                            is_call && full: begin
                                state      <= ST_FAULT;
                                done       <= 1'b1;
                                fault      <= 1'b1;
                                fault_code <= FC_OVF;
                            end
                            is_ret && !empty: begin
                                state   <= ST_POP;
                                stk_pop <= 1'b1;
                            end
                            is_ret && empty: begin
                                state      <= ST_FAULT;
                                done       <= 1'b1;
                                fault      <= 1'b1;
                                fault_code <= FC_UNF;
                            end
                            default: begin
                                state      <= ST_FAULT;
                                done       <= 1'b1;
                                fault      <= 1'b1;
                                fault_code <= FC_ILL;
                            end
                        endcase
                    end
                end
                ST_PUSH: begin
                    depth   <= depth + DW'(1);
                    pc_out  <= PC_W'(tgt_q);
                    done    <= 1'b1;
                    pc_load <= 1'b1;
                    state   <= ST_DONE;
                end
                ST_POP: begin
                    depth <= depth - DW'(1);
                    state <= ST_WAIT;
                end
                // Stack read data lands one cycle after the pop strobe.
                ST_WAIT: begin
                    pc_out  <= stk_rdata[PC_W-1:0];
                    done    <= 1'b1;
                    pc_load <= 1'b1;
                    state   <= ST_DONE;
                end
                ST_DONE:  state <= ST_IDLE;
                ST_FAULT: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_call_ret_ctrl.sv
// Self-checking bench for call_ret_ctrl: directed cases plus random
// requests checked against a queue-based return-stack model.
module tb_call_ret_ctrl;

    localparam int PC_W = 12;
    localparam int SD   = 16;
    localparam int DW   = $clog2(SD) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    call_ret_ctrl_if #(.PC_W(PC_W)) rq ();

    logic [PC_W-1:0] pc_out;
    logic            pc_load;
    logic            done;
    logic            fault;
    logic [1:0]      fault_code;
    logic            stk_push;
    logic            stk_pop;
    logic [15:0]     stk_wdata;
    logic [15:0]     stk_rdata;
    logic [DW-1:0]   depth;

    call_ret_ctrl #(.STACK_DEPTH(SD), .PC_W(PC_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (rq),
        .pc_out     (pc_out),
        .pc_load    (pc_load),
        .done       (done),
        .fault      (fault),
        .fault_code (fault_code),
        .stk_push   (stk_push),
        .stk_pop    (stk_pop),
        .stk_wdata  (stk_wdata),
        .stk_rdata  (stk_rdata),
        .depth      (depth)
    );

    int errors = 0;
    int checks = 0;

    // External stack, discarded whenever the block is reset.
    logic [15:0] env_q[$];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            env_q.delete();
            stk_rdata <= '0;
        end else begin
            if (stk_push) env_q.push_back(stk_wdata);
            if (stk_pop && env_q.size() > 0) stk_rdata <= env_q.pop_back();
        end
    end

    // Reference model: return addresses the architecture should hold.
    logic [PC_W-1:0] ref_q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input logic [15:0] op, input logic [PC_W-1:0] pc,
                           input bit scramble);
        int          exp_lat;
        bit          exp_fault;
        logic [1:0]  exp_code;
        int          exp_push;
        int          exp_pop;
        logic [15:0] exp_wd;
        logic [PC_W-1:0] exp_pc;
        int          got_lat;
        int          n_push;
        int          n_pop;
        logic [15:0] got_wd;
        logic        got_fault;
        logic [1:0]  got_code;
        logic        got_load;
        logic [PC_W-1:0] got_pc;

        exp_push = 0;
        exp_pop  = 0;
        exp_wd   = '0;
        exp_pc   = '0;
        if (op[15:12] == 4'h2) begin
            if (ref_q.size() < SD) begin
                exp_lat = 2; exp_fault = 0; exp_code = 2'd0; exp_push = 1;
                exp_wd  = 16'((int'(pc) + 2) % (1 << PC_W));
                exp_pc  = op[11:0];
                ref_q.push_back(exp_wd[PC_W-1:0]);
            end else begin
                exp_lat = 1; exp_fault = 1; exp_code = 2'd1;
            end
        end else if (op == 16'h00EE) begin
            if (ref_q.size() > 0) begin
                exp_lat = 3; exp_fault = 0; exp_code = 2'd0; exp_pop = 1;
                exp_pc  = ref_q.pop_back();
            end else begin
                exp_lat = 1; exp_fault = 1; exp_code = 2'd2;
            end
        end else begin
            exp_lat = 1; exp_fault = 1; exp_code = 2'd3;
        end

        @(negedge clk);
        chk("ready_before", rq.req_ready, 1);
        rq.req_valid = 1'b1;
        rq.opcode    = op;
        rq.pc_in     = pc;
        @(posedge clk);
        #1;
        rq.req_valid = 1'b0;
        if (scramble) begin
            rq.opcode = 16'($urandom);
            rq.pc_in  = PC_W'($urandom);
        end

        got_lat = 0; n_push = 0; n_pop = 0; got_wd = '0;
        got_fault = 0; got_code = 0; got_load = 0; got_pc = '0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("push_pop_excl", {31'd0, stk_push & stk_pop}, 0);
            if (stk_push) begin n_push++; got_wd = stk_wdata; end
            if (stk_pop) n_pop++;
            if (done) begin
                got_lat   = c;
                got_fault = fault;
                got_code  = fault_code;
                got_load  = pc_load;
                got_pc    = pc_out;
                break;
            end
        end
        chk("done_seen", got_lat != 0, 1);
        chk("latency", got_lat, exp_lat);
        chk("fault", got_fault, exp_fault);
        chk("fault_code", got_code, exp_code);
        chk("pc_load", got_load, !exp_fault);
        if (!exp_fault) chk("pc_out", got_pc, exp_pc);
        chk("push_count", n_push, exp_push);
        chk("pop_count", n_pop, exp_pop);
        if (exp_push == 1) chk("stk_wdata", got_wd, exp_wd);

        @(negedge clk);
        chk("depth", depth, ref_q.size());
        chk("code_held", fault_code, exp_code);
        chk("done_one_shot", done, 0);
        chk("ready_after", rq.req_ready, 1);
    endtask

    initial begin
        int r;
        logic [15:0] op;

        rq.req_valid = 1'b0;
        rq.opcode    = '0;
        rq.pc_in     = '0;
        repeat (3) @(negedge clk);
        chk("rst_depth", depth, 0);
        chk("rst_pc_out", pc_out, 0);
        chk("rst_done", done, 0);
        chk("rst_code", fault_code, 0);
        chk("rst_push", stk_push, 0);
        chk("rst_pop", stk_pop, 0);
        chk("rst_ready", rq.req_ready, 1);
        rst_n = 1'b1;

        run_req(16'h2345, 12'h200, 1'b0);
        run_req(16'h00EE, 12'h400, 1'b1);
        run_req(16'h00EE, 12'h123, 1'b0);

        for (int i = 0; i < SD; i++)
            run_req({4'h2, 12'($urandom)}, PC_W'($urandom), 1'b1);
        run_req(16'h2ABC, 12'h300, 1'b0);
        for (int i = 0; i < SD; i++)
            run_req(16'h00EE, PC_W'($urandom), 1'b1);

        run_req(16'h1234, 12'h222, 1'b0);
        run_req(16'h2800, 12'hFFE, 1'b0);
        run_req(16'h00EE, 12'h010, 1'b0);

        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      op = {4'h2, 12'($urandom)};
            else if (r < 9) op = 16'h00EE;
            else            op = 16'($urandom);
            run_req(op, PC_W'($urandom), 1'b1);
        end

        // Reset asserted while a RET is waiting on stack data.
        if (ref_q.size() == 0) run_req(16'h2111, 12'h500, 1'b0);
        @(negedge clk);
        rq.req_valid = 1'b1;
        rq.opcode    = 16'h00EE;
        rq.pc_in     = 12'h0;
        @(posedge clk);
        #1 rq.req_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("wrst_ready", rq.req_ready, 1);
        chk("wrst_depth", depth, 0);
        chk("wrst_done", done, 0);
        chk("wrst_load", pc_load, 0);
        chk("wrst_pc_out", pc_out, 0);
        chk("wrst_code", fault_code, 0);
        chk("wrst_pop", stk_pop, 0);
        #1 rst_n = 1'b1;
        ref_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_done", done, 0);
            chk("post_rst_load", pc_load, 0);
        end
        run_req(16'h00EE, 12'h000, 1'b0);
        run_req(16'h2456, 12'h0FE, 1'b0);
        run_req(16'h00EE, 12'h000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
